instruction_sequencer: RTL and testbench

Instruction buffer and issue stage that sits directly upstream of the control unit. The host preloads a program of 23-bit instruction words through a write port; on `start`, the block replays them one per cycle onto the `instruction` bus that the control unit decodes. Between and after programs, the block drives an all-zero bubble: `nn_start` = 0 and load code 00, so no loads occur.

---
 rtl/instruction_sequencer.sv | 154 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction buffer and issue stage feeding the control unit.
// The host preloads up to DEPTH instruction words. On start, the block replays
// them one per cycle on 'instruction'. When no program word is being issued,
// the block drives an all-zero bubble (nn_start = 0, load code 00).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en/wr_data - host append port (IDLE only)
//   clear        - empty the buffer / abort a run
//   start        - replay the stored program
//   stall        - downstream hold; forces a bubble for the cycle
//   instruction/instr_valid - registered issue bus
//   busy, done, wr_err      - status (done/wr_err are one-cycle pulses)
//   count, pc               - words stored / next word index
module instruction_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned INSTR_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [INSTR_W-1:0]         wr_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stall,
  output logic [INSTR_W-1:0]         instruction,
  output logic                       instr_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [INSTR_W-1:0] mem [DEPTH];

  logic [INSTR_W-1:0] instr_d;
  logic               valid_d, busy_d, done_d, wr_err_d, mem_we;
  logic [CW-1:0]      count_d;
  logic [AW-1:0]      pc_d;
  logic               last_word;

  // pc addresses the final stored word
  assign last_word = (CW'(pc) == (count - CW'(1)));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    instr_d  = '0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    mem_we   = 1'b0;
    count_d  = count;
    pc_d     = pc;
    unique case (state)
      IDLE: begin
        if (clear) begin
          count_d = '0;                   // any concurrent write is dropped silently
        end else if (start) begin
          wr_err_d = wr_en;               // start wins over a concurrent write
          pc_d     = '0;
          if (count != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;               // empty program: straight to done, never busy
          end
        end else if (wr_en) begin
          if (count < CW'(DEPTH)) begin
            mem_we  = 1'b1;
            count_d = count + CW'(1);
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          pc_d    = '0;
          count_d = '0;
        end else begin
          wr_err_d = wr_en;
          busy_d   = 1'b1;                // stays high through the last word
          if (!stall) begin
            instr_d = mem[pc];
            valid_d = 1'b1;
            if (last_word) begin
              state_d = DONE;             // pc held so it never passes count-1
            end else begin
              pc_d = pc + AW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pc_d    = '0;
        if (clear) begin
          count_d = '0;
        end else begin
          done_d   = 1'b1;
          wr_err_d = wr_en;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instruction <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
      count       <= '0;
      pc          <= '0;
    end else begin
      state       <= state_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      busy        <= busy_d;
      done        <= done_d;
      wr_err      <= wr_err_d;
      count       <= count_d;
      pc          <= pc_d;
    end
  end

  // Program storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned INSTR_W = 23;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en, clear, start, stall;
  logic [INSTR_W-1:0] wr_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid, busy, done, wr_err;
  logic [4:0]         count;
  logic [3:0]         pc;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        wr_en;
    logic [22:0] wr_data;
    logic        clear;
    logic        start;
    logic        stall;
    logic [22:0] e_instr;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic [4:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  instruction_sequencer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .stall(stall),
    .instruction(instruction), .instr_valid(instr_valid), .busy(busy),
    .done(done), .wr_err(wr_err), .count(count), .pc(pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
  endtask

  task automatic add(input logic w, input logic [22:0] d, input logic c, input logic s,
                     input logic st, input logic [22:0] ei, input logic ev,
                     input logic eb, input logic ed, input logic ee, input logic [4:0] ec);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.clear = c; v.start = s; v.stall = st;
    v.e_instr = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    v.e_count = ec;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then check the outputs registered at that edge
  task automatic step(input vec_t v, input int idx);
    wr_en = v.wr_en; wr_data = v.wr_data; clear = v.clear;
    start = v.start; stall = v.stall;
    @(posedge clk);
    #1;
    check("instruction", idx, 32'(instruction), 32'(v.e_instr));
    check("instr_valid", idx, 32'(instr_valid), 32'(v.e_valid));
    check("busy",        idx, 32'(busy),        32'(v.e_busy));
    check("done",        idx, 32'(done),        32'(v.e_done));
    check("wr_err",      idx, 32'(wr_err),      32'(v.e_err));
    check("count",       idx, 32'(count),       32'(v.e_count));
    wr_en = 1'b0; clear = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  task automatic idle_step(input logic [22:0] ei, input logic ev, input logic eb,
                           input logic ed, input logic ee, input logic [4:0] ec,
                           input int idx);
    vec_t v;
    v.wr_en = 0; v.wr_data = '0; v.clear = 0; v.start = 0; v.stall = 0;
    v.e_instr = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    v.e_count = ec;
    step(v, idx);
  endtask

  task automatic drive(input logic w, input logic [22:0] d, input logic c, input logic s,
                       input logic [22:0] ei, input logic ev, input logic eb,
                       input logic ed, input logic ee, input logic [4:0] ec, input int idx);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.clear = c; v.start = s; v.stall = 0;
    v.e_instr = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_err = ee;
    v.e_count = ec;
    step(v, idx);
  endtask

  initial begin
    logic [22:0] fill [17];

    rst_n = 1'b0; wr_en = 0; wr_data = '0; clear = 0; start = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instruction", 0, 32'(instruction), 32'h0);
    check("rst_valid",       0, 32'(instr_valid), 32'h0);
    check("rst_busy",        0, 32'(busy),        32'h0);
    check("rst_count",       0, 32'(count),       32'h0);
    check("rst_pc",          0, 32'(pc),          32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //   wr  data      clr st stl | instr     v  b  d  e  cnt
    // Basic 3-word program
    add(1, 23'h400004, 0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd1);
    add(1, 23'h000008, 0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd2);
    add(1, 23'h00000D, 0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd3);
    add(0, 23'h0,      0, 1, 0,   23'h0,      0, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h400004, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h000008, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h00000D, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 1, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd3);
    // start+wr_en drops the write with wr_err; one stall after the first word
    add(1, 23'h7FFFFF, 0, 1, 0,   23'h0,      0, 1, 0, 1, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h400004, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 1,   23'h0,      0, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h000008, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h00000D, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 1, 0, 5'd3);
    // Mid-run write is dropped
    add(0, 23'h0,      0, 1, 0,   23'h0,      0, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h400004, 1, 1, 0, 0, 5'd3);
    add(1, 23'h123456, 0, 0, 0,   23'h000008, 1, 1, 0, 1, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h00000D, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 1, 0, 5'd3);
    // Replay shows the program unchanged
    add(0, 23'h0,      0, 1, 0,   23'h0,      0, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h400004, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h000008, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h00000D, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 1, 0, 5'd3);
    // Mid-run clear aborts with no done
    add(0, 23'h0,      0, 1, 0,   23'h0,      0, 1, 0, 0, 5'd3);
    add(0, 23'h0,      0, 0, 0,   23'h400004, 1, 1, 0, 0, 5'd3);
    add(0, 23'h0,      1, 0, 0,   23'h0,      0, 0, 0, 0, 5'd0);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd0);
    // Empty start: done one cycle later, never busy or valid
    add(0, 23'h0,      0, 1, 0,   23'h0,      0, 0, 0, 0, 5'd0);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 1, 0, 5'd0);
    add(0, 23'h0,      0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd0);
    // clear+wr_en drops the write silently
    add(1, 23'h000001, 0, 0, 0,   23'h0,      0, 0, 0, 0, 5'd1);
    add(1, 23'h000002, 1, 0, 0,   23'h0,      0, 0, 0, 0, 5'd0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Overfill: DEPTH+1 writes, wr_err only on the last
    for (int i = 0; i < 17; i++) begin
      fill[i] = 23'(i * 37 + 5);
      drive(1, fill[i], 0, 0, 23'h0, 0, 0, 0, (i == 16), 5'((i < 16) ? i + 1 : 16), 100 + i);
    end
    drive(0, 23'h0, 0, 1, 23'h0, 0, 1, 0, 0, 5'd16, 120);
    for (int i = 0; i < 16; i++) idle_step(fill[i], 1, 1, 0, 0, 5'd16, 130 + i);
    idle_step(23'h0, 0, 0, 1, 0, 5'd16, 150);

    // Asynchronous reset during word 2 of 3
    drive(0, 23'h0, 1, 0, 23'h0, 0, 0, 0, 0, 5'd0, 200);
    drive(1, 23'h400004, 0, 0, 23'h0, 0, 0, 0, 0, 5'd1, 201);
    drive(1, 23'h000008, 0, 0, 23'h0, 0, 0, 0, 0, 5'd2, 202);
    drive(1, 23'h00000D, 0, 0, 23'h0, 0, 0, 0, 0, 5'd3, 203);
    drive(0, 23'h0, 0, 1, 23'h0, 0, 1, 0, 0, 5'd3, 204);
    idle_step(23'h400004, 1, 1, 0, 0, 5'd3, 205);
    idle_step(23'h000008, 1, 1, 0, 0, 5'd3, 206);
    #2 rst_n = 1'b0;
    #1;
    check("async_instruction", 207, 32'(instruction), 32'h0);
    check("async_valid",       207, 32'(instr_valid), 32'h0);
    check("async_busy",        207, 32'(busy),        32'h0);
    check("async_count",       207, 32'(count),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 23'h0, 0, 1, 23'h0, 0, 0, 0, 0, 5'd0, 208);
    idle_step(23'h0, 0, 0, 1, 0, 5'd0, 209);
    idle_step(23'h0, 0, 0, 0, 0, 5'd0, 210);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
